// File: rtl/trdb_pkg.sv
// Shared constants and types for the trace debugger packet merger.
package trdb_pkg;

   localparam logic [1:0] TRDB_MSG_SW    = 2'b11;
   localparam logic [1:0] TRDB_SUB_USER  = 2'b00;
   localparam logic [1:0] TRDB_SUB_TIMER = 2'b01;
   localparam int         SW_PACKET_LEN  = 36;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } trdb_flush_e;

endpackage

// File: rtl/trdb_timer.sv
// Free-running trace timer plus a one-entry holder for timer packet requests.
module trdb_timer
   import trdb_pkg::*;
#(
   parameter int TIMER_WIDTH = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   trace_enable_i,
   input  logic                   clear_i,
   input  logic                   tu_req_i,
   input  logic                   tu_grant_i,
   output logic                   tu_pend_o,
   output logic [TIMER_WIDTH-1:0] tu_value_o,
   output logic                   tu_drop_o
);

   logic [TIMER_WIDTH-1:0] timer_q, timer_d;
   logic [TIMER_WIDTH-1:0] tu_value_q, tu_value_d;
   logic                   tu_pend_q, tu_pend_d;

   always_comb begin
      timer_d    = trace_enable_i ? timer_q + TIMER_WIDTH'(1) : timer_q;
      tu_pend_d  = tu_pend_q;
      tu_value_d = tu_value_q;
      tu_drop_o  = 1'b0;
      if (clear_i) begin
         tu_pend_d = 1'b0;
      end else begin
         if (tu_grant_i) tu_pend_d = 1'b0;
         // A new request replaces the held one; only a drop if the old one was not emitted now.
         if (tu_req_i) begin
            tu_pend_d  = 1'b1;
            tu_value_d = timer_q;
            tu_drop_o  = tu_pend_q & ~tu_grant_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         timer_q    <= '0;
         tu_value_q <= '0;
         tu_pend_q  <= 1'b0;
      end else begin
         timer_q    <= timer_d;
         tu_value_q <= tu_value_d;
         tu_pend_q  <= tu_pend_d;
      end
   end

   assign tu_pend_o  = tu_pend_q;
   assign tu_value_o = tu_value_q;

endmodule

// File: rtl/trdb_packet_merger.sv
// Merges trace, timer and software packets into one registered stream with a flush handshake.
//  state | meaning
//  IDLE  | no flush in progress
//  DRAIN | flush requested, waiting for all sources and the output register to empty
//  DONE  | drain confirmed, waiting for flush_stream_i to drop
module trdb_packet_merger
   import trdb_pkg::*;
#(
   parameter int PKT_WIDTH     = 128,
   parameter int PKT_LEN_WIDTH = 7,
   parameter int TIMER_WIDTH   = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     trace_enable_i,
   input  logic                     clear_i,
   input  logic [PKT_WIDTH-1:0]     trace_packet_i,
   input  logic [PKT_LEN_WIDTH-1:0] trace_packet_len_i,
   input  logic                     trace_valid_i,
   output logic                     trace_grant_o,
   input  logic [31:0]              sw_word_i,
   input  logic                     sw_valid_i,
   output logic                     sw_grant_o,
   input  logic                     tu_req_i,
   output logic                     tu_drop_o,
   input  logic                     flush_stream_i,
   output logic                     flush_confirm_o,
   output logic [PKT_WIDTH-1:0]     packet_o,
   output logic [PKT_LEN_WIDTH-1:0] packet_len_o,
   output logic                     packet_valid_o,
   input  logic                     packet_ready_i
);

   logic                     tu_pend;
   logic [TIMER_WIDTH-1:0]   tu_value;
   logic                     tu_grant;
   logic                     load;
   logic                     arb_en;
   logic [PKT_WIDTH-1:0]     sw_pkt, tu_pkt;

   logic [PKT_WIDTH-1:0]     packet_q, packet_d;
   logic [PKT_LEN_WIDTH-1:0] packet_len_q, packet_len_d;
   logic                     packet_valid_q, packet_valid_d;
   trdb_flush_e              state_q, state_d;

   trdb_timer #(
      .TIMER_WIDTH (TIMER_WIDTH)
   ) u_timer (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .trace_enable_i (trace_enable_i),
      .clear_i        (clear_i),
      .tu_req_i       (tu_req_i),
      .tu_grant_i     (tu_grant),
      .tu_pend_o      (tu_pend),
      .tu_value_o     (tu_value),
      .tu_drop_o      (tu_drop_o)
   );

   always_comb begin
      sw_pkt        = '0;
      sw_pkt[35:4]  = sw_word_i;
      sw_pkt[3:2]   = TRDB_SUB_USER;
      sw_pkt[1:0]   = TRDB_MSG_SW;
      tu_pkt        = '0;
      tu_pkt[TIMER_WIDTH+3:4] = tu_value;
      tu_pkt[3:2]   = TRDB_SUB_TIMER;
      tu_pkt[1:0]   = TRDB_MSG_SW;
   end

   // Fixed priority trace > timer > software; clear_i suppresses every grant.
   always_comb begin
      load           = ~packet_valid_q | packet_ready_i;
      arb_en         = load & ~clear_i;
      trace_grant_o  = arb_en & trace_valid_i;
      tu_grant       = arb_en & ~trace_valid_i & tu_pend;
      sw_grant_o     = arb_en & ~trace_valid_i & ~tu_pend & sw_valid_i;

      packet_d       = packet_q;
      packet_len_d   = packet_len_q;
      packet_valid_d = packet_valid_q;
      if (clear_i) begin
         packet_valid_d = 1'b0;
      end else if (load) begin
         packet_valid_d = trace_grant_o | tu_grant | sw_grant_o;
         if (trace_grant_o) begin
            packet_d     = trace_packet_i;
            packet_len_d = trace_packet_len_i;
         end else if (tu_grant) begin
            packet_d     = tu_pkt;
            packet_len_d = PKT_LEN_WIDTH'(TIMER_WIDTH + 4);
         end else if (sw_grant_o) begin
            packet_d     = sw_pkt;
            packet_len_d = PKT_LEN_WIDTH'(SW_PACKET_LEN);
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      flush_confirm_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (flush_stream_i) state_d = DRAIN;
         end
         DRAIN: begin
            if (!flush_stream_i) begin
               state_d = IDLE;
            end else if (!trace_valid_i && !sw_valid_i && !tu_pend && !packet_valid_q) begin
               state_d         = DONE;
               flush_confirm_o = 1'b1;
            end
         end
         DONE: begin
            if (!flush_stream_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         packet_q       <= '0;
         packet_len_q   <= '0;
         packet_valid_q <= 1'b0;
         state_q        <= IDLE;
      end else begin
         packet_q       <= packet_d;
         packet_len_q   <= packet_len_d;
         packet_valid_q <= packet_valid_d;
         state_q        <= state_d;
      end
   end

   assign packet_o       = packet_q;
   assign packet_len_o   = packet_len_q;
   assign packet_valid_o = packet_valid_q;

endmodule
